// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the RV32 pipeline hazard controller.
// Forwarding-select codes and the branch-flush FSM state encodings live here.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXMEM   = 2'd1;
    localparam logic [1:0] FWD_MEMWB   = 2'd2;
    localparam logic [1:0] FWD_WB      = 2'd3;

    typedef enum logic {
        HC_RUN      = 1'b0,
        HC_FLUSH_BR = 1'b1
    } hc_state_e;

    // Youngest producer wins: EX over MEM over WB.
    function automatic logic [1:0] fwd_pick(input logic hit_ex,
                                            input logic hit_mem,
                                            input logic hit_wb);
        if (hit_ex)       return FWD_EXMEM;
        else if (hit_mem) return FWD_MEMWB;
        else if (hit_wb)  return FWD_WB;
        else              return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot (EX/MEM/WB) tracker of in-flight destination registers.
// Produces the load-use hazard flag and next-cycle forwarding selects.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv_i,
    input  logic                  iss_vld_i,
    input  logic [REG_ADDR_W-1:0] iss_rd_i,
    input  logic                  iss_is_load_i,
    input  logic                  id_vld_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    output logic                  load_use_o,
    output logic [1:0]            fwd_rs1_nxt_o,
    output logic [1:0]            fwd_rs2_nxt_o
);

    logic                  ex_vld_q, mem_vld_q, wb_vld_q;
    logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    // Only the EX slot's load flag matters: a load in MEM or later is forwardable.
    logic                  ex_is_load_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld_q     <= 1'b0;
            mem_vld_q    <= 1'b0;
            wb_vld_q     <= 1'b0;
            ex_rd_q      <= '0;
            mem_rd_q     <= '0;
            wb_rd_q      <= '0;
            ex_is_load_q <= 1'b0;
        end else if (adv_i) begin
            wb_vld_q     <= mem_vld_q;
            wb_rd_q      <= mem_rd_q;
            mem_vld_q    <= ex_vld_q;
            mem_rd_q     <= ex_rd_q;
            ex_vld_q     <= iss_vld_i;
            ex_rd_q      <= iss_rd_i;
            ex_is_load_q <= iss_is_load_i;
        end
    end

    logic ex_ok, mem_ok, wb_ok;
    logic h1_ex, h1_mem, h1_wb;
    logic h2_ex, h2_mem, h2_wb;

    assign ex_ok  = ex_vld_q  & (ex_rd_q  != '0);
    assign mem_ok = mem_vld_q & (mem_rd_q != '0);
    assign wb_ok  = wb_vld_q  & (wb_rd_q  != '0);

    assign h1_ex  = id_use_rs1_i & ex_ok  & (ex_rd_q  == id_rs1_i);
    assign h1_mem = id_use_rs1_i & mem_ok & (mem_rd_q == id_rs1_i);
    assign h1_wb  = id_use_rs1_i & wb_ok  & (wb_rd_q  == id_rs1_i);
    assign h2_ex  = id_use_rs2_i & ex_ok  & (ex_rd_q  == id_rs2_i);
    assign h2_mem = id_use_rs2_i & mem_ok & (mem_rd_q == id_rs2_i);
    assign h2_wb  = id_use_rs2_i & wb_ok  & (wb_rd_q  == id_rs2_i);

    assign load_use_o    = id_vld_i & ex_is_load_q & (h1_ex | h2_ex);
    assign fwd_rs1_nxt_o = id_vld_i ? fwd_pick(h1_ex, h1_mem, h1_wb) : FWD_REGFILE;
    assign fwd_rs2_nxt_o = id_vld_i ? fwd_pick(h2_ex, h2_mem, h2_wb) : FWD_REGFILE;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/bubble/flush priority, branch-flush FSM,
// registered EX forwarding selects and stall/flush performance counters.
//
// state       | meaning
// HC_RUN      | normal issue; ID instruction is live
// HC_FLUSH_BR | cycle after a taken branch; squash the in-flight fetch, ID is dead
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_vld,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_wr_rd,
    input  logic                  id_is_load,
    input  logic                  id_jmp_vld,
    input  logic                  ex_br_taken,
    input  logic                  mem_stall,
    output logic                  if_stall,
    output logic                  id_stall,
    output logic                  ex_bubble,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            fwd_rs1,
    output logic [1:0]            fwd_rs2,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    hc_state_e        state_q, state_d;
    logic [1:0]       fwd_rs1_q, fwd_rs2_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic       id_live;
    logic       issue;
    logic       load_use;
    logic [1:0] fwd_rs1_nxt, fwd_rs2_nxt;

    // The ID slot during FLUSH_BR holds the cleared IF/ID contents.
    assign id_live = id_vld & (state_q == HC_RUN);

    hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
        .clk           (clk),
        .rst           (rst),
        .adv_i         (~mem_stall),
        .iss_vld_i     (issue & id_live & id_wr_rd),
        .iss_rd_i      (id_rd),
        .iss_is_load_i (id_is_load),
        .id_vld_i      (id_live),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_use_rs1_i  (id_use_rs1),
        .id_use_rs2_i  (id_use_rs2),
        .load_use_o    (load_use),
        .fwd_rs1_nxt_o (fwd_rs1_nxt),
        .fwd_rs2_nxt_o (fwd_rs2_nxt)
    );

    always_comb begin
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        ex_bubble   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        issue       = 1'b0;
        state_d     = state_q;
        if (rst) begin
            state_d = HC_RUN;
        end else if (mem_stall) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
        end else if (ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = HC_FLUSH_BR;
        end else if (state_q == HC_FLUSH_BR) begin
            if_id_flush = 1'b1;
            issue       = 1'b1;
            state_d     = HC_RUN;
        end else if (load_use) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
        end else begin
            issue       = 1'b1;
            if_id_flush = id_jmp_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HC_RUN;
            fwd_rs1_q   <= FWD_REGFILE;
            fwd_rs2_q   <= FWD_REGFILE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, id_stall};
            flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, if_id_flush};
            if (!mem_stall) begin
                fwd_rs1_q <= issue ? fwd_rs1_nxt : FWD_REGFILE;
                fwd_rs2_q <= issue ? fwd_rs2_nxt : FWD_REGFILE;
            end
        end
    end

    assign fwd_rs1   = fwd_rs1_q;
    assign fwd_rs2   = fwd_rs2_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios then random traffic,
// all checked against an in-bench model of the in-flight register window.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, id_vld, id_use_rs1, id_use_rs2, id_wr_rd, id_is_load;
    logic        id_jmp_vld, ex_br_taken, mem_stall;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        if_stall, id_stall, ex_bubble, if_id_flush, id_ex_flush;
    logic [1:0]  fwd_rs1, fwd_rs2;
    logic [31:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_wr_rd(id_wr_rd), .id_is_load(id_is_load), .id_jmp_vld(id_jmp_vld),
        .ex_br_taken(ex_br_taken), .mem_stall(mem_stall), .if_stall(if_stall),
        .id_stall(id_stall), .ex_bubble(ex_bubble), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Model: in-flight writers, index 0 = EX, 1 = MEM, 2 = WB.
    bit          m_vld[3];
    bit          m_ld[3];
    logic [4:0]  m_rd[3];
    bit          m_fl;
    logic [1:0]  m_f1, m_f2;
    logic [31:0] m_sc, m_fc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input int k, input logic [4:0] r);
        return m_vld[k] && (m_rd[k] != 5'd0) && (m_rd[k] == r);
    endfunction

    function automatic logic [1:0] youngest(input bit used, input logic [4:0] r);
        if (used)
            for (int k = 0; k < 3; k++)
                if (hit(k, r)) return 2'(k + 1);
        return 2'd0;
    endfunction

    task automatic idle();
        id_vld = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_wr_rd = 0; id_is_load = 0; id_jmp_vld = 0; ex_br_taken = 0; mem_stall = 0; rst = 0;
    endtask

    task automatic ins(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit wr, input bit ld);
        idle();
        id_vld = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_wr_rd = wr; id_is_load = ld;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        bit live, lu, issue;
        bit e_ifs, e_ids, e_bub, e_iff, e_idf;
        logic [1:0] n1, n2;
        #1;
        live = id_vld && !m_fl;
        lu = live && m_vld[0] && m_ld[0] &&
             ((id_use_rs1 && hit(0, id_rs1)) || (id_use_rs2 && hit(0, id_rs2)));
        e_ifs = 0; e_ids = 0; e_bub = 0; e_iff = 0; e_idf = 0;
        if (!rst) begin
            if (mem_stall) begin e_ifs = 1; e_ids = 1; end
            else if (ex_br_taken) begin e_iff = 1; e_idf = 1; end
            else if (m_fl) e_iff = 1;
            else if (lu) begin e_ifs = 1; e_ids = 1; e_bub = 1; end
            else if (id_jmp_vld) e_iff = 1;
        end
        chk("if_stall",    32'(if_stall),    32'(e_ifs));
        chk("id_stall",    32'(id_stall),    32'(e_ids));
        chk("ex_bubble",   32'(ex_bubble),   32'(e_bub));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_iff));
        chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
        chk("fwd_rs1",     32'(fwd_rs1),     32'(m_f1));
        chk("fwd_rs2",     32'(fwd_rs2),     32'(m_f2));
        chk("stall_cnt",   stall_cnt,        m_sc);
        chk("flush_cnt",   flush_cnt,        m_fc);
        if (rst) begin
            for (int k = 0; k < 3; k++) begin m_vld[k] = 0; m_ld[k] = 0; m_rd[k] = 0; end
            m_fl = 0; m_f1 = 0; m_f2 = 0; m_sc = 0; m_fc = 0;
        end else begin
            m_sc = m_sc + 32'(e_ids);
            m_fc = m_fc + 32'(e_iff);
            if (!mem_stall) begin
                issue = !ex_br_taken && !lu && live;
                n1 = issue ? youngest(id_use_rs1, id_rs1) : 2'd0;
                n2 = issue ? youngest(id_use_rs2, id_rs2) : 2'd0;
                m_vld[2] = m_vld[1]; m_rd[2] = m_rd[1]; m_ld[2] = m_ld[1];
                m_vld[1] = m_vld[0]; m_rd[1] = m_rd[0]; m_ld[1] = m_ld[0];
                m_vld[0] = issue && id_wr_rd; m_rd[0] = id_rd; m_ld[0] = id_is_load;
                m_f1 = n1; m_f2 = n2;
                m_fl = ex_br_taken;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1; step(); step();
        idle(); step();
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_fwd_rs1", 32'(fwd_rs1), 32'd0);

        // LW x5 then ADD x6,x5,x2
        ins(5, 1, 0, 1, 0, 1, 1); step();
        ins(6, 5, 2, 1, 1, 1, 0); step(); step();
        chk("lu_fwd_rs1", 32'(fwd_rs1), 32'd2);
        chk("lu_fwd_rs2", 32'(fwd_rs2), 32'd0);
        chk("lu_stall_cnt", stall_cnt, 32'd1);

        // ADDI x3 then readers at distance 1, 2, 3
        ins(3, 0, 0, 1, 0, 1, 0); step();
        ins(4, 3, 3, 1, 1, 1, 0); step();
        chk("d1_fwd_rs1", 32'(fwd_rs1), 32'd1);
        chk("d1_fwd_rs2", 32'(fwd_rs2), 32'd1);
        ins(3, 0, 0, 1, 0, 1, 0); step();
        ins(10, 0, 0, 0, 0, 1, 0); step();
        ins(4, 3, 3, 1, 1, 1, 0); step();
        chk("d2_fwd_rs1", 32'(fwd_rs1), 32'd2);
        chk("d2_fwd_rs2", 32'(fwd_rs2), 32'd2);
        ins(3, 0, 0, 1, 0, 1, 0); step();
        ins(10, 0, 0, 0, 0, 1, 0); step();
        ins(11, 0, 0, 0, 0, 1, 0); step();
        ins(4, 3, 3, 1, 1, 1, 0); step();
        chk("d3_fwd_rs1", 32'(fwd_rs1), 32'd3);
        chk("d3_fwd_rs2", 32'(fwd_rs2), 32'd3);

        // x0 writer (a load) then x0 reader
        ins(0, 1, 0, 1, 0, 1, 1); step();
        ins(12, 0, 0, 1, 1, 1, 0); step();
        chk("x0_fwd_rs1", 32'(fwd_rs1), 32'd0);
        chk("x0_fwd_rs2", 32'(fwd_rs2), 32'd0);
        chk("x0_stall_cnt", stall_cnt, 32'd1);

        // Taken branch over a load-use hazard
        ins(7, 1, 0, 1, 0, 1, 1); step();
        ins(8, 7, 0, 1, 0, 1, 0); ex_br_taken = 1; step();
        idle(); step();
        chk("br_flush_cnt", flush_cnt, 32'd2);
        ins(13, 8, 7, 1, 1, 1, 0); step();
        chk("br_no_entry", 32'(fwd_rs1), 32'd0);
        chk("br_ld_wb", 32'(fwd_rs2), 32'd3);

        // JAL alone, then JAL under a taken branch
        ins(1, 0, 0, 0, 0, 1, 0); id_jmp_vld = 1; step();
        ins(14, 1, 0, 1, 0, 1, 0); step();
        chk("jal_flush_cnt", flush_cnt, 32'd3);
        chk("jal_issued", 32'(fwd_rs1), 32'd1);
        ins(1, 0, 0, 0, 0, 1, 0); id_jmp_vld = 1; ex_br_taken = 1; step();
        idle(); step();
        chk("jalbr_flush_cnt", flush_cnt, 32'd5);

        // mem_stall for 3 cycles with a load in MEM
        ins(9, 0, 0, 0, 0, 1, 1); step();
        idle(); step();
        idle(); mem_stall = 1; step(); step(); step();
        chk("ms_stall_cnt", stall_cnt, 32'd4);
        ins(15, 9, 0, 1, 0, 1, 0); step();
        chk("ms_hold_fwd", 32'(fwd_rs1), 32'd2);

        // Reset in the middle of a memory stall
        ins(9, 0, 0, 0, 0, 1, 1); step();
        idle(); mem_stall = 1; step();
        rst = 1; step();
        idle(); #1;
        chk("rst_if_stall", 32'(if_stall), 32'd0);
        chk("rst_id_stall", 32'(id_stall), 32'd0);
        chk("rst_scnt", stall_cnt, 32'd0);
        chk("rst_fcnt", flush_cnt, 32'd0);
        chk("rst_fwd", 32'({fwd_rs1, fwd_rs2}), 32'd0);
        ins(16, 9, 9, 1, 1, 1, 0); step();
        chk("rst_sb_clear", 32'(fwd_rs1), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            idle();
            rst         = ($urandom % 64) == 0;
            id_vld      = ($urandom % 4) != 0;
            id_rs1      = 5'($urandom % 4);
            id_rs2      = 5'($urandom % 4);
            id_rd       = 5'($urandom % 4);
            id_use_rs1  = 1'($urandom % 2);
            id_use_rs2  = 1'($urandom % 2);
            id_wr_rd    = ($urandom % 4) != 0;
            id_is_load  = ($urandom % 3) == 0;
            id_jmp_vld  = ($urandom % 10) == 0;
            ex_br_taken = ($urandom % 10) == 0;
            mem_stall   = ($urandom % 8) == 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
